// File: rtl/fetch_unit_if.sv
// Instruction memory word port: address/controls from the fetch side, read data back one cycle later.
interface mem_if;
  logic [31:0] addr;
  logic        write_en;
  logic [3:0]  data_en;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport driver (output addr, write_en, data_en, data_i, input data_o);
  modport memory (input addr, write_en, data_en, data_i, output data_o);
  modport master (output addr, write_en, data_en, data_i, input data_o);
  modport slave  (input addr, write_en, data_en, data_i, output data_o);
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues 1-cycle imem reads, buffers {word, pc} for decode (head visible at 0 latency).
// Backpressure: issue stalls once buffered + in-flight reaches DEPTH; a redirect flushes all wrong-path work.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  mem_if.driver       imem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t        buf_q [DEPTH];
  entry_t        buf_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          req_q, req_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          push, pop, issue;
  logic [PW+1:0] outstanding;

  assign imem.addr     = fetch_pc_q;
  assign imem.write_en = 1'b0;
  assign imem.data_en  = 4'b1111;
  assign imem.data_i   = '0;

  assign instr_valid = (count_q != '0);
  assign instr       = buf_q[rd_ptr_q].instr;
  assign instr_pc    = buf_q[rd_ptr_q].pc;

  always_comb begin
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    req_d      = 1'b0;
    req_pc_d   = req_pc_q;
    fetch_pc_d = fetch_pc_q;

    // Pops are not credited to issue, so a push can never land in a full buffer.
    outstanding = {1'b0, count_q} + (PW+2)'(req_q);
    pop         = instr_valid && instr_ready;
    push        = req_q && !redirect_valid;
    issue       = !reset && !redirect_valid && (outstanding < DEPTH_W);

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        buf_d[wr_ptr_q] = '{instr: imem.data_o, pc: req_pc_q};
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
      if (issue) begin
        req_d      = 1'b1;
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      req_pc_q   <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_q      <= buf_d;
    end
  end
endmodule
